// File: rtl/player_move_ctrl_if.sv
// rtl/player_move_ctrl_if.sv - bus bundle between input/wall memory side and player_move_ctrl
//
// Purpose: groups the direction pulses, wall memory read port and the
// player status outputs of player_move_ctrl.
// Signals:
//   btn_pulse    [3:0]  one-cycle direction pulses {up, down, left, right}
//   wall_addr    [7:0]  wall memory address of the current cell
//   wall_data    [3:0]  wall mask of addressed cell {up, down, left, right}, 1 = wall
//   player_x     [3:0]  current column
//   player_y     [3:0]  current row
//   busy                move request in progress
//   bump                one-cycle pulse on rejected move
//   goal_reached        sticky goal flag
//   move_count   [15:0] four BCD digits of accepted moves
// Modports: master = input handler / wall memory side, slave = player_move_ctrl.

interface player_move_ctrl_if;
  logic [3:0]  btn_pulse;
  logic [7:0]  wall_addr;
  logic [3:0]  wall_data;
  logic [3:0]  player_x;
  logic [3:0]  player_y;
  logic        busy;
  logic        bump;
  logic        goal_reached;
  logic [15:0] move_count;

  modport master (
    output btn_pulse,
    output wall_data,
    input  wall_addr,
    input  player_x,
    input  player_y,
    input  busy,
    input  bump,
    input  goal_reached,
    input  move_count
  );

  modport slave (
    input  btn_pulse,
    input  wall_data,
    output wall_addr,
    output player_x,
    output player_y,
    output busy,
    output bump,
    output goal_reached,
    output move_count
  );
endinterface

// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - turns direction pulses into wall/bounds-checked maze moves
//
// Purpose: latches one direction per request, reads the current cell's wall
// mask (1-cycle synchronous memory), rejects moves blocked by walls or the grid
// edge, updates the registered position, flags goal arrival and keeps a
// saturating BCD move count.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    player_move_ctrl_if.slave (btn_pulse, wall_data in; wall_addr,
//          player_x, player_y, busy, bump, goal_reached, move_count out)
// Configuration macro: MOVE_COUNTER_EN - when defined the BCD move counter is
// built; when undefined move_count is tied to 16'h0000.

module player_move_ctrl #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 12,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 15,
  parameter int GOAL_Y  = 11
) (
  input logic          clk,
  input logic          reset,
  player_move_ctrl_if.slave bus
);

  localparam logic [3:0] X_MAX   = 4'(GRID_W - 1);
  localparam logic [3:0] Y_MAX   = 4'(GRID_H - 1);
  localparam logic [3:0] X_START = 4'(START_X);
  localparam logic [3:0] Y_START = 4'(START_Y);
  localparam logic [3:0] X_GOAL  = 4'(GOAL_X);
  localparam logic [3:0] Y_GOAL  = 4'(GOAL_Y);
  localparam logic [7:0] W_8     = 8'(GRID_W);
  localparam logic [7:0] ADDR0   = 8'(START_Y * GRID_W + START_X);

  // Direction is held one-hot in the same bit order as btn_pulse/wall_data,
  // so the wall test is a simple AND.
  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CHECK} state_t;

  state_t      r_state;
  logic [3:0]  r_dir;
  logic [3:0]  r_x;
  logic [3:0]  r_y;
  logic [7:0]  r_addr;
  logic        r_busy;
  logic        r_bump;
  logic        r_goal;

  logic [3:0]  w_sel_dir;
  logic [3:0]  w_new_x;
  logic [3:0]  w_new_y;
  logic [7:0]  w_new_addr;
  logic        w_oob;
  logic        w_blocked;
  logic        w_at_goal;

  // Fixed priority up > down > left > right; the rest of the pulse is dropped.
  always_comb begin
    w_sel_dir = 4'b0000;
    if (bus.btn_pulse[3])      w_sel_dir = DIR_UP;
    else if (bus.btn_pulse[2]) w_sel_dir = DIR_DOWN;
    else if (bus.btn_pulse[1]) w_sel_dir = DIR_LEFT;
    else if (bus.btn_pulse[0]) w_sel_dir = DIR_RIGHT;
  end

  // Grid edge wins over memory contents so bad wall data can never move the
  // player off the grid (and the +/-1 below never wraps).
  assign w_oob = (r_dir[3] && (r_y == 4'd0))  ||
                 (r_dir[2] && (r_y == Y_MAX)) ||
                 (r_dir[1] && (r_x == 4'd0))  ||
                 (r_dir[0] && (r_x == X_MAX));

  assign w_blocked = w_oob || (|(r_dir & bus.wall_data));

  always_comb begin
    w_new_x = r_x;
    w_new_y = r_y;
    if (r_dir[3])      w_new_y = r_y - 4'd1;
    else if (r_dir[2]) w_new_y = r_y + 4'd1;
    else if (r_dir[1]) w_new_x = r_x - 4'd1;
    else if (r_dir[0]) w_new_x = r_x + 4'd1;
  end

  assign w_new_addr = ({4'b0000, w_new_y} * W_8) + {4'b0000, w_new_x};
  assign w_at_goal  = (w_new_x == X_GOAL) && (w_new_y == Y_GOAL);

`ifdef MOVE_COUNTER_EN
  logic [15:0] r_count;

  // Four-digit BCD increment that holds at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (res[i*4 +: 4] == 4'd9) begin
            res[i*4 +: 4] = 4'd0;
          end else begin
            res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

  assign bus.move_count = r_count;
`else
  assign bus.move_count = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dir   <= 4'b0000;
      r_x     <= X_START;
      r_y     <= Y_START;
      r_addr  <= ADDR0;
      r_busy  <= 1'b0;
      r_bump  <= 1'b0;
      r_goal  <= 1'b0;
`ifdef MOVE_COUNTER_EN
      r_count <= 16'h0000;
`endif
    end else begin
      r_bump <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_goal && (bus.btn_pulse != 4'b0000)) begin
            r_dir   <= w_sel_dir;
            r_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        // wall_addr has been stable since the last move; this cycle covers
        // the memory read latency so wall_data is valid in CHECK.
        S_READ: r_state <= S_CHECK;
        S_CHECK: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (w_blocked) begin
            r_bump <= 1'b1;
          end else begin
            r_x    <= w_new_x;
            r_y    <= w_new_y;
            r_addr <= w_new_addr;
            if (w_at_goal) r_goal <= 1'b1;
`ifdef MOVE_COUNTER_EN
            r_count <= bcd_inc(r_count);
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wall_addr    = r_addr;
  assign bus.player_x     = r_x;
  assign bus.player_y     = r_y;
  assign bus.busy         = r_busy;
  assign bus.bump         = r_bump;
  assign bus.goal_reached = r_goal;

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb/tb_player_move_ctrl.sv - directed self-checking bench for player_move_ctrl

module tb_player_move_ctrl;

`ifdef MOVE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   npass;
  int   nfail;
  int   ntotal;

  player_move_ctrl_if bus_if ();

  player_move_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ec(input logic [15:0] v);
    return CNT_EN ? v : 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input logic [3:0] x, input logic [3:0] y);
    chk($sformatf("%s.x", tag), 16'(bus_if.player_x), 16'(x));
    chk($sformatf("%s.y", tag), 16'(bus_if.player_y), 16'(y));
  endtask

  // Called at a negedge with the DUT idle; returns at the N+3 negedge.
  task automatic do_move(input logic [3:0] dir, input logic [3:0] wd,
                         input bit check_busy, input string tag);
    bus_if.wall_data = wd;
    bus_if.btn_pulse = dir;
    @(negedge clk);
    bus_if.btn_pulse = 4'b0000;
    if (check_busy) chk($sformatf("%s.busy1", tag), 16'(bus_if.busy), 16'h1);
    @(negedge clk);
    if (check_busy) chk($sformatf("%s.busy2", tag), 16'(bus_if.busy), 16'h1);
    @(negedge clk);
    if (check_busy) chk($sformatf("%s.busy3", tag), 16'(bus_if.busy), 16'h0);
  endtask

  initial begin
    npass  = 0;
    nfail  = 0;
    ntotal = 0;
    reset  = 1'b1;
    bus_if.btn_pulse = 4'b0000;
    bus_if.wall_data = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk_pos("rst", 4'd0, 4'd0);
    chk("rst.addr", 16'(bus_if.wall_addr), 16'd0);
    chk("rst.busy", 16'(bus_if.busy), 16'h0);
    chk("rst.bump", 16'(bus_if.bump), 16'h0);
    chk("rst.goal", 16'(bus_if.goal_reached), 16'h0);
    chk("rst.cnt", bus_if.move_count, 16'h0000);

    do_move(4'b0001, 4'b0000, 1'b1, "right1");
    chk_pos("right1", 4'd1, 4'd0);
    chk("right1.addr", 16'(bus_if.wall_addr), 16'd1);
    chk("right1.cnt", bus_if.move_count, ec(16'h0001));
    chk("right1.bump", 16'(bus_if.bump), 16'h0);

    do_move(4'b0010, 4'b0000, 1'b1, "left1");
    chk_pos("left1", 4'd0, 4'd0);
    chk("left1.cnt", bus_if.move_count, ec(16'h0002));

    do_move(4'b1000, 4'b0000, 1'b1, "up_edge");
    chk("up_edge.bump", 16'(bus_if.bump), 16'h1);
    chk_pos("up_edge", 4'd0, 4'd0);
    chk("up_edge.cnt", bus_if.move_count, ec(16'h0002));
    @(negedge clk);
    chk("up_edge.bump_off", 16'(bus_if.bump), 16'h0);

    do_move(4'b0010, 4'b0000, 1'b1, "left_edge");
    chk("left_edge.bump", 16'(bus_if.bump), 16'h1);
    chk_pos("left_edge", 4'd0, 4'd0);

    for (int i = 0; i < 3; i++) do_move(4'b0001, 4'b0000, 1'b0, "walk_r");
    for (int i = 0; i < 2; i++) do_move(4'b0100, 4'b0000, 1'b0, "walk_d");
    chk_pos("at32", 4'd3, 4'd2);
    chk("at32.addr", 16'(bus_if.wall_addr), 16'd35);
    chk("at32.cnt", bus_if.move_count, ec(16'h0007));

    do_move(4'b0010, 4'b0010, 1'b1, "wall_left");
    chk("wall_left.bump", 16'(bus_if.bump), 16'h1);
    chk_pos("wall_left", 4'd3, 4'd2);
    chk("wall_left.cnt", bus_if.move_count, ec(16'h0007));

    do_move(4'b0100, 4'b0010, 1'b1, "down33");
    chk_pos("down33", 4'd3, 4'd3);
    chk("down33.addr", 16'(bus_if.wall_addr), 16'd51);
    chk("down33.cnt", bus_if.move_count, ec(16'h0008));
    chk("down33.bump", 16'(bus_if.bump), 16'h0);

    // Multi-bit pulse resolves to up; a pulse during READ is dropped.
    bus_if.wall_data = 4'b0000;
    bus_if.btn_pulse = 4'b1001;
    @(negedge clk);
    bus_if.btn_pulse = 4'b0001;
    @(negedge clk);
    bus_if.btn_pulse = 4'b0000;
    @(negedge clk);
    chk_pos("prio", 4'd3, 4'd2);
    chk("prio.addr", 16'(bus_if.wall_addr), 16'd35);
    chk("prio.cnt", bus_if.move_count, ec(16'h0009));
    repeat (3) @(negedge clk);
    chk_pos("drop", 4'd3, 4'd2);
    chk("drop.busy", 16'(bus_if.busy), 16'h0);

    for (int i = 0; i < 12; i++) do_move(4'b0001, 4'b0000, 1'b0, "walk_r2");
    for (int i = 0; i < 8; i++) do_move(4'b0100, 4'b0000, 1'b0, "walk_d2");
    chk_pos("at1510", 4'd15, 4'd10);
    chk("at1510.addr", 16'(bus_if.wall_addr), 16'd175);
    chk("at1510.cnt", bus_if.move_count, ec(16'h0029));

    do_move(4'b0001, 4'b0000, 1'b1, "right_edge");
    chk("right_edge.bump", 16'(bus_if.bump), 16'h1);
    chk_pos("right_edge", 4'd15, 4'd10);

    do_move(4'b0100, 4'b0100, 1'b1, "wall_down");
    chk("wall_down.bump", 16'(bus_if.bump), 16'h1);
    chk("wall_down.goal", 16'(bus_if.goal_reached), 16'h0);

    do_move(4'b0100, 4'b0000, 1'b1, "goal");
    chk_pos("goal", 4'd15, 4'd11);
    chk("goal.flag", 16'(bus_if.goal_reached), 16'h1);
    chk("goal.addr", 16'(bus_if.wall_addr), 16'd191);
    chk("goal.cnt", bus_if.move_count, ec(16'h0030));

    bus_if.btn_pulse = 4'b1000;
    @(negedge clk);
    bus_if.btn_pulse = 4'b0000;
    chk("post_goal.busy1", 16'(bus_if.busy), 16'h0);
    @(negedge clk);
    chk("post_goal.busy2", 16'(bus_if.busy), 16'h0);
    @(negedge clk);
    chk_pos("post_goal", 4'd15, 4'd11);
    chk("post_goal.bump", 16'(bus_if.bump), 16'h0);
    chk("post_goal.cnt", bus_if.move_count, ec(16'h0030));

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2.goal", 16'(bus_if.goal_reached), 16'h0);
    chk_pos("rst2", 4'd0, 4'd0);

    // Reset while the move is in READ.
    bus_if.btn_pulse = 4'b0001;
    @(negedge clk);
    bus_if.btn_pulse = 4'b0000;
    chk("abort.busy_read", 16'(bus_if.busy), 16'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_pos("abort", 4'd0, 4'd0);
    chk("abort.busy", 16'(bus_if.busy), 16'h0);
    chk("abort.addr", 16'(bus_if.wall_addr), 16'd0);
    chk("abort.cnt", bus_if.move_count, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort.late_bump", 16'(bus_if.bump), 16'h0);
      chk("abort.late_x", 16'(bus_if.player_x), 16'h0);
    end
    chk("abort.late_cnt", bus_if.move_count, 16'h0000);

`ifdef MOVE_COUNTER_EN
    for (int i = 0; i < 4999; i++) begin
      do_move(4'b0001, 4'b0000, 1'b0, "pre_r");
      do_move(4'b0010, 4'b0000, 1'b0, "pre_l");
    end
    chk("pre.cnt", bus_if.move_count, 16'h9998);
    chk_pos("pre", 4'd0, 4'd0);
`endif
    do_move(4'b0001, 4'b0000, 1'b1, "sat1");
    chk_pos("sat1", 4'd1, 4'd0);
    chk("sat1.cnt", bus_if.move_count, CNT_EN ? 16'h9999 : 16'h0000);
    do_move(4'b0010, 4'b0000, 1'b1, "sat2");
    chk_pos("sat2", 4'd0, 4'd0);
    chk("sat2.cnt", bus_if.move_count, CNT_EN ? 16'h9999 : 16'h0000);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
